// File: rtl/fp_addsub_pipe.sv
// ---------------------------------------------------------------------------
// fp_addsub_pipe
// Fully pipelined IEEE-754 adder/subtractor (round-to-nearest-even, denormals
// flushed to zero) with an opaque tag, exception flags and valid/ready
// backpressure. All stages advance together and all hold together on a stall.
//
// Pipeline: S1 unpack/classify/swap -> S2 align -> S3 add/sub -> S4 normalise
// -> output register (round, pack, flags). An operation accepted on edge N
// is presented with out_valid=1 after edge N+4 when no stall occurs.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  operation handshake; in_ready depends only on out_valid
//                   and out_ready
//   in_a, in_b      operands {sign, exponent, fraction}
//   in_sub          0: a+b, 1: a-b
//   in_tag          sideband returned unchanged with the result
//   out_valid/ready result handshake
//   out_data        result
//   out_tag         tag of the operation that produced out_data
//   out_flags       {invalid, overflow, underflow, inexact}
//   busy            any of the four internal stages holds a valid operation
// ---------------------------------------------------------------------------
module fp_addsub_pipe #(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52,
    parameter int TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic                 in_sub,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_data,
    output logic [TAG_W-1:0]     out_tag,
    output logic [3:0]           out_flags,
    output logic                 busy
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int MV   = MAN_W + 4;            // hidden + fraction + G/R/S
    localparam int EW   = EXP_W + 2;            // exponent with carry and sign room
    localparam int LZ_W = $clog2(MV) + 1;
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    // Leading-zero count of a normalisation vector; the highest set bit wins.
    function automatic logic [LZ_W-1:0] lzc(input logic [MV-1:0] v);
        logic [LZ_W-1:0] n;
        n = LZ_W'(MV);
        for (int i = 0; i < MV; i++) begin
            n = v[i] ? LZ_W'(MV - 1 - i) : n;
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic w_adv;
    logic r_out_valid;

    assign w_adv    = !(r_out_valid && !out_ready);
    assign in_ready = w_adv;

    // ------------------------------------------------------------------
    // S1: unpack, classify, specials, magnitude swap
    // ------------------------------------------------------------------
    logic               w_a_sgn, w_b_sgn;
    logic [EXP_W-1:0]   w_a_exp, w_b_exp;
    logic [MAN_W-1:0]   w_a_frc, w_b_frc;
    logic               w_a_zero, w_b_zero, w_a_inf, w_b_inf;
    logic               w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_infinf;
    logic [W-2:0]       w_a_key, w_b_key;
    logic [MAN_W:0]     w_a_man, w_b_man;
    logic               w_swap;
    logic               w_s1_spc, w_s1_inv;
    logic [W-1:0]       w_s1_spv;

    assign w_a_sgn  = in_a[W-1];
    assign w_a_exp  = in_a[W-2:MAN_W];
    assign w_a_frc  = in_a[MAN_W-1:0];
    // Subtraction is folded into the effective sign of b.
    assign w_b_sgn  = in_b[W-1] ^ in_sub;
    assign w_b_exp  = in_b[W-2:MAN_W];
    assign w_b_frc  = in_b[MAN_W-1:0];

    // Exponent zero covers both true zero and flushed denormals.
    assign w_a_zero = (w_a_exp == {EXP_W{1'b0}});
    assign w_b_zero = (w_b_exp == {EXP_W{1'b0}});
    assign w_a_inf  = (w_a_exp == EXP_ONES) && (w_a_frc == {MAN_W{1'b0}});
    assign w_b_inf  = (w_b_exp == EXP_ONES) && (w_b_frc == {MAN_W{1'b0}});
    assign w_a_nan  = (w_a_exp == EXP_ONES) && (w_a_frc != {MAN_W{1'b0}});
    assign w_b_nan  = (w_b_exp == EXP_ONES) && (w_b_frc != {MAN_W{1'b0}});
    assign w_a_snan = w_a_nan && !w_a_frc[MAN_W-1];
    assign w_b_snan = w_b_nan && !w_b_frc[MAN_W-1];
    assign w_infinf = w_a_inf && w_b_inf && (w_a_sgn != w_b_sgn);

    // Magnitude keys treat flushed denormals as zero so the swap agrees
    // with the mantissas that are actually used.
    assign w_a_key  = w_a_zero ? {(W-1){1'b0}} : in_a[W-2:0];
    assign w_b_key  = w_b_zero ? {(W-1){1'b0}} : in_b[W-2:0];
    assign w_a_man  = w_a_zero ? {(MAN_W+1){1'b0}} : {1'b1, w_a_frc};
    assign w_b_man  = w_b_zero ? {(MAN_W+1){1'b0}} : {1'b1, w_b_frc};
    assign w_swap   = (w_b_key > w_a_key);

    // Special-case result selection; these bypass the arithmetic path.
    always_comb begin
        w_s1_spc = 1'b0;
        w_s1_spv = {W{1'b0}};
        w_s1_inv = 1'b0;
        if (w_a_nan || w_b_nan || w_infinf) begin
            w_s1_spc = 1'b1;
            w_s1_spv = QNAN;
            w_s1_inv = w_a_snan || w_b_snan || w_infinf;
        end else if (w_a_inf) begin
            w_s1_spc = 1'b1;
            w_s1_spv = {w_a_sgn, EXP_ONES, {MAN_W{1'b0}}};
        end else if (w_b_inf) begin
            w_s1_spc = 1'b1;
            w_s1_spv = {w_b_sgn, EXP_ONES, {MAN_W{1'b0}}};
        end else begin
            w_s1_spc = 1'b0;
            w_s1_spv = {W{1'b0}};
        end
    end

    logic               r_s1_valid, r_s1_sgn, r_s1_eff_sub, r_s1_spc, r_s1_inv, r_s1_zsgn;
    logic [TAG_W-1:0]   r_s1_tag;
    logic [EXP_W-1:0]   r_s1_exp, r_s1_diff;
    logic [MAN_W:0]     r_s1_xm, r_s1_ym;
    logic [W-1:0]       r_s1_spv;

    // S1 register: larger-magnitude operand lands in x.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_tag     <= {TAG_W{1'b0}};
            r_s1_sgn     <= 1'b0;
            r_s1_eff_sub <= 1'b0;
            r_s1_exp     <= {EXP_W{1'b0}};
            r_s1_diff    <= {EXP_W{1'b0}};
            r_s1_xm      <= {(MAN_W+1){1'b0}};
            r_s1_ym      <= {(MAN_W+1){1'b0}};
            r_s1_spc     <= 1'b0;
            r_s1_spv     <= {W{1'b0}};
            r_s1_inv     <= 1'b0;
            r_s1_zsgn    <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid   <= in_valid;
            r_s1_tag     <= in_tag;
            r_s1_sgn     <= w_swap ? w_b_sgn : w_a_sgn;
            r_s1_eff_sub <= w_a_sgn ^ w_b_sgn;
            r_s1_exp     <= w_swap ? w_b_exp : w_a_exp;
            r_s1_diff    <= w_swap ? (w_b_exp - w_a_exp) : (w_a_exp - w_b_exp);
            r_s1_xm      <= w_swap ? w_b_man : w_a_man;
            r_s1_ym      <= w_swap ? w_a_man : w_b_man;
            r_s1_spc     <= w_s1_spc;
            r_s1_spv     <= w_s1_spv;
            r_s1_inv     <= w_s1_inv;
            // Sign of an exact zero: negative only when both inputs are.
            r_s1_zsgn    <= w_a_sgn & w_b_sgn;
        end
    end

    // ------------------------------------------------------------------
    // S2: align the smaller mantissa, collecting guard/round/sticky
    // ------------------------------------------------------------------
    logic [2*MV-1:0] w_s2_dbl;
    logic [MV-1:0]   w_s2_ym;

    // Shift into a double-width window; the lower half is what falls off.
    always_comb begin
        w_s2_dbl = {r_s1_ym, 3'b000, {MV{1'b0}}} >> r_s1_diff;
        if (32'(r_s1_diff) >= 32'(MAN_W + 3)) begin
            w_s2_ym = {{(MV-1){1'b0}}, |r_s1_ym};
        end else begin
            w_s2_ym = w_s2_dbl[2*MV-1:MV] | {{(MV-1){1'b0}}, |w_s2_dbl[MV-1:0]};
        end
    end

    logic               r_s2_valid, r_s2_sgn, r_s2_eff_sub, r_s2_spc, r_s2_inv, r_s2_zsgn;
    logic [TAG_W-1:0]   r_s2_tag;
    logic [EXP_W-1:0]   r_s2_exp;
    logic [MV-1:0]      r_s2_xm, r_s2_ym;
    logic [W-1:0]       r_s2_spv;

    // S2 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid   <= 1'b0;
            r_s2_tag     <= {TAG_W{1'b0}};
            r_s2_sgn     <= 1'b0;
            r_s2_eff_sub <= 1'b0;
            r_s2_exp     <= {EXP_W{1'b0}};
            r_s2_xm      <= {MV{1'b0}};
            r_s2_ym      <= {MV{1'b0}};
            r_s2_spc     <= 1'b0;
            r_s2_spv     <= {W{1'b0}};
            r_s2_inv     <= 1'b0;
            r_s2_zsgn    <= 1'b0;
        end else if (w_adv) begin
            r_s2_valid   <= r_s1_valid;
            r_s2_tag     <= r_s1_tag;
            r_s2_sgn     <= r_s1_sgn;
            r_s2_eff_sub <= r_s1_eff_sub;
            r_s2_exp     <= r_s1_exp;
            r_s2_xm      <= {r_s1_xm, 3'b000};
            r_s2_ym      <= w_s2_ym;
            r_s2_spc     <= r_s1_spc;
            r_s2_spv     <= r_s1_spv;
            r_s2_inv     <= r_s1_inv;
            r_s2_zsgn    <= r_s1_zsgn;
        end
    end

    // ------------------------------------------------------------------
    // S3: magnitude add/subtract (x >= y, so the difference is never negative)
    // ------------------------------------------------------------------
    logic [MV:0] w_s3_sum;

    assign w_s3_sum = r_s2_eff_sub ? ({1'b0, r_s2_xm} - {1'b0, r_s2_ym})
                                   : ({1'b0, r_s2_xm} + {1'b0, r_s2_ym});

    logic               r_s3_valid, r_s3_sgn, r_s3_spc, r_s3_inv, r_s3_zsgn;
    logic [TAG_W-1:0]   r_s3_tag;
    logic [EXP_W-1:0]   r_s3_exp;
    logic [MV:0]        r_s3_sum;
    logic [W-1:0]       r_s3_spv;

    // S3 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_valid <= 1'b0;
            r_s3_tag   <= {TAG_W{1'b0}};
            r_s3_sgn   <= 1'b0;
            r_s3_exp   <= {EXP_W{1'b0}};
            r_s3_sum   <= {(MV+1){1'b0}};
            r_s3_spc   <= 1'b0;
            r_s3_spv   <= {W{1'b0}};
            r_s3_inv   <= 1'b0;
            r_s3_zsgn  <= 1'b0;
        end else if (w_adv) begin
            r_s3_valid <= r_s2_valid;
            r_s3_tag   <= r_s2_tag;
            r_s3_sgn   <= r_s2_sgn;
            r_s3_exp   <= r_s2_exp;
            r_s3_sum   <= w_s3_sum;
            r_s3_spc   <= r_s2_spc;
            r_s3_spv   <= r_s2_spv;
            r_s3_inv   <= r_s2_inv;
            r_s3_zsgn  <= r_s2_zsgn;
        end
    end

    // ------------------------------------------------------------------
    // S4: normalise so the hidden bit sits at MV-1
    // ------------------------------------------------------------------
    logic [LZ_W-1:0] w_s4_lz;
    logic [MV-1:0]   w_s4_norm;
    logic [EW-1:0]   w_s4_exp;
    logic            w_s4_zero;

    // Carry-out shifts right by one (keeping sticky); otherwise shift left.
    // The exponent may go negative here, which reads as underflow later.
    always_comb begin
        w_s4_lz   = lzc(r_s3_sum[MV-1:0]);
        w_s4_zero = (r_s3_sum == {(MV+1){1'b0}});
        if (r_s3_sum[MV]) begin
            w_s4_norm = {r_s3_sum[MV:2], r_s3_sum[1] | r_s3_sum[0]};
            w_s4_exp  = {2'b00, r_s3_exp} + {{(EW-1){1'b0}}, 1'b1};
        end else begin
            w_s4_norm = r_s3_sum[MV-1:0] << w_s4_lz;
            w_s4_exp  = {2'b00, r_s3_exp} - EW'(w_s4_lz);
        end
    end

    logic               r_s4_valid, r_s4_sgn, r_s4_zero, r_s4_spc, r_s4_inv, r_s4_zsgn;
    logic [TAG_W-1:0]   r_s4_tag;
    logic [EW-1:0]      r_s4_exp;
    logic [MV-1:0]      r_s4_norm;
    logic [W-1:0]       r_s4_spv;

    // S4 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s4_valid <= 1'b0;
            r_s4_tag   <= {TAG_W{1'b0}};
            r_s4_sgn   <= 1'b0;
            r_s4_exp   <= {EW{1'b0}};
            r_s4_norm  <= {MV{1'b0}};
            r_s4_zero  <= 1'b0;
            r_s4_spc   <= 1'b0;
            r_s4_spv   <= {W{1'b0}};
            r_s4_inv   <= 1'b0;
            r_s4_zsgn  <= 1'b0;
        end else if (w_adv) begin
            r_s4_valid <= r_s3_valid;
            r_s4_tag   <= r_s3_tag;
            r_s4_sgn   <= r_s3_sgn;
            r_s4_exp   <= w_s4_exp;
            r_s4_norm  <= w_s4_norm;
            r_s4_zero  <= w_s4_zero;
            r_s4_spc   <= r_s3_spc;
            r_s4_spv   <= r_s3_spv;
            r_s4_inv   <= r_s3_inv;
            r_s4_zsgn  <= r_s3_zsgn;
        end
    end

    // ------------------------------------------------------------------
    // Output stage: round to nearest even, pack, flags
    // ------------------------------------------------------------------
    logic             w_o_up, w_o_inx, w_o_unf;
    logic [MAN_W+1:0] w_o_man;
    logic [EW-1:0]    w_o_exp;
    logic [MAN_W-1:0] w_o_frc;
    logic [W-1:0]     w_o_data;
    logic [3:0]       w_o_flags;

    assign w_o_up  = r_s4_norm[2] & (r_s4_norm[1] | r_s4_norm[0] | r_s4_norm[3]);
    assign w_o_inx = r_s4_norm[2] | r_s4_norm[1] | r_s4_norm[0];
    assign w_o_man = {1'b0, r_s4_norm[MV-1:3]} + {{(MAN_W+1){1'b0}}, w_o_up};
    assign w_o_unf = r_s4_exp[EW-1] || (r_s4_exp == {EW{1'b0}});

    // Result selection in priority order: special, exact zero, underflow,
    // overflow, normal. A rounding carry bumps the exponent and clears
    // the fraction.
    always_comb begin
        w_o_exp   = r_s4_exp;
        w_o_frc   = w_o_man[MAN_W-1:0];
        w_o_data  = {W{1'b0}};
        w_o_flags = 4'b0000;
        if (w_o_man[MAN_W+1]) begin
            w_o_exp = r_s4_exp + {{(EW-1){1'b0}}, 1'b1};
            w_o_frc = w_o_man[MAN_W:1];
        end else begin
            w_o_exp = r_s4_exp;
            w_o_frc = w_o_man[MAN_W-1:0];
        end
        if (r_s4_spc) begin
            w_o_data  = r_s4_spv;
            w_o_flags = {r_s4_inv, 3'b000};
        end else if (r_s4_zero) begin
            w_o_data  = {r_s4_zsgn, {(W-1){1'b0}}};
            w_o_flags = 4'b0000;
        end else if (w_o_unf) begin
            w_o_data  = {r_s4_sgn, {(W-1){1'b0}}};
            w_o_flags = 4'b0011;
        end else if (w_o_exp >= {2'b00, EXP_ONES}) begin
            w_o_data  = {r_s4_sgn, EXP_ONES, {MAN_W{1'b0}}};
            w_o_flags = 4'b0101;
        end else begin
            w_o_data  = {r_s4_sgn, w_o_exp[EXP_W-1:0], w_o_frc};
            w_o_flags = {3'b000, w_o_inx};
        end
    end

    logic [W-1:0]     r_out_data;
    logic [TAG_W-1:0] r_out_tag;
    logic [3:0]       r_out_flags;

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= {W{1'b0}};
            r_out_tag   <= {TAG_W{1'b0}};
            r_out_flags <= 4'b0000;
        end else if (w_adv) begin
            r_out_valid <= r_s4_valid;
            r_out_data  <= w_o_data;
            r_out_tag   <= r_s4_tag;
            r_out_flags <= w_o_flags;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;
    assign out_flags = r_out_flags;
    assign busy      = r_s1_valid | r_s2_valid | r_s3_valid | r_s4_valid;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_addsub_pipe
// Directed bench for fp_addsub_pipe (double precision, 8-bit tag): reset
// state, arithmetic and exception vectors with 4-cycle latency, a tagged
// backpressure stream, and reset while operations are in flight.
// ---------------------------------------------------------------------------
module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        in_sub;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [7:0]  out_tag;
    logic [3:0]  out_flags;
    logic        busy;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] ONE = 64'h3FF0000000000000;

    fp_addsub_pipe #(.EXP_W(11), .MAN_W(52), .TAG_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_flags (out_flags),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Exact double encoding of a small positive integer.
    function automatic logic [63:0] i2d(input int n);
        int          e;
        logic [51:0] f;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        f = 52'(n - (1 << e));
        f = f << (52 - e);
        return {1'b0, 11'(1023 + e), f};
    endfunction

    // One operation into an empty pipeline with out_ready high.
    task automatic run_one(input string name, input logic [63:0] a, input logic [63:0] b,
                           input logic sub, input logic [7:0] tag,
                           input logic [63:0] exp_d, input logic [3:0] exp_f);
        int lat;
        @(negedge clk);
        in_a = a; in_b = b; in_sub = sub; in_tag = tag; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'd4);
        chk({name, "_data"},    out_data, exp_d);
        chk({name, "_tag"},     64'(out_tag), 64'(tag));
        chk({name, "_flags"},   64'(out_flags), 64'(exp_f));
    endtask

    int         sent;
    int         got;
    int         cyc;
    int         stalls;
    int         extra;
    logic [7:0] lfsr;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = 64'd0; in_b = 64'd0; in_sub = 1'b0; in_tag = 8'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_out_data",  out_data,       64'd0);
        chk("rst_out_tag",   64'(out_tag),   64'd0);
        chk("rst_out_flags", 64'(out_flags), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),  64'd1);

        // Arithmetic and exception vectors
        run_one("add_1_2",   ONE, 64'h4000000000000000, 1'b0, 8'h5A, 64'h4008000000000000, 4'b0000);
        run_one("sub_1_1",   ONE, ONE,                  1'b1, 8'h11, 64'h0000000000000000, 4'b0000);
        run_one("rne_tie",   ONE, 64'h3CA0000000000000, 1'b0, 8'h12, 64'h3FF0000000000000, 4'b0001);
        run_one("rne_up",    64'h3FF0000000000001, 64'h3CA0000000000000, 1'b0, 8'h13,
                64'h3FF0000000000002, 4'b0001);
        run_one("overflow",  64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 1'b0, 8'h14,
                64'h7FF0000000000000, 4'b0101);
        run_one("inf_m_inf", 64'h7FF0000000000000, 64'h7FF0000000000000, 1'b1, 8'h15,
                64'h7FF8000000000000, 4'b1000);
        run_one("underflow", 64'h0010000000000001, 64'h0010000000000000, 1'b1, 8'h16,
                64'h0000000000000000, 4'b0011);
        run_one("negz_negz", 64'h8000000000000000, 64'h8000000000000000, 1'b0, 8'h17,
                64'h8000000000000000, 4'b0000);
        run_one("ninf_p_1",  64'hFFF0000000000000, ONE, 1'b0, 8'h18,
                64'hFFF0000000000000, 4'b0000);
        run_one("qnan_in",   64'h7FF8000000000001, ONE, 1'b0, 8'h19,
                64'h7FF8000000000000, 4'b0000);

        // Backpressure: 16 tagged ops, results (tag + 2) checked in order
        sent = 0; got = 0; cyc = 0; stalls = 0; lfsr = 8'hA5;
        while (got < 16 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            out_ready = lfsr[0];
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                chk("bp_in_ready_stall", 64'(in_ready), 64'd0);
            end else begin
                chk("bp_in_ready_flow", 64'(in_ready), 64'd1);
            end
            if (out_valid) begin
                chk("bp_tag",   64'(out_tag),   64'(got));
                chk("bp_data",  out_data,       i2d(got + 2));
                chk("bp_flags", 64'(out_flags), 64'd0);
                if (out_ready) got++;
            end
            in_valid = (sent < 16);
            if (sent < 16) begin
                in_tag = 8'(sent);
                in_sub = sent[0];
                in_a   = sent[0] ? i2d(sent + 3) : i2d(sent + 1);
                in_b   = ONE;
                if (in_ready) sent++;
            end
        end
        chk("bp_results", 64'(got), 64'd16);
        chk("bp_stalled", 64'(stalls > 0), 64'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("bp_no_extra", 64'(extra), 64'd0);
        chk("bp_idle_busy", 64'(busy), 64'd0);

        // Reset while operations are in flight
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_a = ONE; in_b = ONE; in_sub = 1'b0; in_tag = 8'(8'h31 + i); in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_out_valid_before", 64'(out_valid), 64'd1);
        chk("mid_busy_before",      64'(busy),      64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_out_valid_async", 64'(out_valid), 64'd0);
        chk("mid_busy_async",      64'(busy),      64'd0);
        chk("mid_out_data_async",  out_data,       64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_in_ready", 64'(in_ready), 64'd1);
        run_one("post_rst", ONE, ONE, 1'b0, 8'h77, 64'h4000000000000000, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
